// File: rtl/mips_mem_pkg.sv
// Shared types for the multicycle MIPS memory-port sequencer.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RSP
    } memstate_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane logic: byte enables, write replication, read extraction/extension.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] rdata_ext,
    output logic        illegal
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte    = readdata[{addr_lo, 3'b000} +: 8];
        rd_half    = addr_lo[1] ? readdata[31:16] : readdata[15:0];
        byteenable = '0;
        writedata  = '0;
        rdata_ext  = '0;
        illegal    = 1'b0;
        case (size)
            SZ_BYTE: begin
                byteenable = 4'b0001 << addr_lo;
                writedata  = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
                writedata  = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign_ext & rd_half[15]}}, rd_half};
                illegal    = addr_lo[0];
            end
            SZ_WORD: begin
                byteenable = 4'b1111;
                writedata  = wdata;
                rdata_ext  = readdata;
                illegal    = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mem_ctrl.sv
// One-request-at-a-time sequencer from the CPU memory port to an Avalon master with
// waitrequest, illegal-request detection and a stall watchdog.
module mips_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [3:0]  avl_byteenable,
    output logic [31:0] avl_writedata,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    memstate_t        state;
    logic [1:0]       lat_size;
    logic             lat_signed;
    logic [1:0]       lat_addr_lo;
    logic [CNT_W-1:0] wd_cnt;

    logic       in_idle;
    logic [1:0] al_size;
    logic       al_signed;
    logic [1:0] al_addr_lo;
    logic [3:0] al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic       al_illegal;
    logic       timeout_hit;

    // Aligner sees the live request while idle, the latched one during the access.
    assign in_idle    = (state == IDLE);
    assign al_size    = in_idle ? req_size     : lat_size;
    assign al_signed  = in_idle ? req_signed   : lat_signed;
    assign al_addr_lo = in_idle ? req_addr[1:0] : lat_addr_lo;

    // This stall cycle is the one that brings the count up to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == TO_LAST);

    mem_lane_align u_align (
        .size       (al_size),
        .sign_ext   (al_signed),
        .addr_lo    (al_addr_lo),
        .wdata      (req_wdata),
        .readdata   (avl_readdata),
        .byteenable (al_be),
        .writedata  (al_wdata),
        .rdata_ext  (al_rdata),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= '0;
            avl_address    <= '0;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            avl_byteenable <= '0;
            avl_writedata  <= '0;
            lat_size       <= '0;
            lat_signed     <= 1'b0;
            lat_addr_lo    <= '0;
            wd_cnt         <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready      <= 1'b0;
                        lat_size       <= req_size;
                        lat_signed     <= req_signed;
                        lat_addr_lo    <= req_addr[1:0];
                        avl_address    <= {req_addr[31:2], 2'b00};
                        avl_byteenable <= al_be;
                        avl_writedata  <= al_wdata;
                        wd_cnt         <= '0;
                        if (al_illegal) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_write) begin
                            state     <= WR;
                            avl_write <= 1'b1;
                        end else begin
                            state     <= RD;
                            avl_read  <= 1'b1;
                        end
                    end
                end
                RD, WR: begin
                    if (!avl_waitrequest) begin
                        avl_read  <= 1'b0;
                        avl_write <= 1'b0;
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= (state == RD) ? al_rdata : '0;
                    end else if (timeout_hit) begin
                        avl_read  <= 1'b0;
                        avl_write <= 1'b0;
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RSP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
